cpu_run_ctrl: RTL and testbench

- Debug/execution controller that sequences the single-cycle RV32I core.
- Produces a per-cycle advance enable, cpu_en, which gates PC update, register-file write and data-memory write in the integration top.
- Supports halt, single-step, free run, run-N and a PC breakpoint.
- Can dump all 32 GPRs over a valid/ready stream by driving the core's debug reg_sel/reg_data port.

---
 rtl/cpu_run_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debug/execution controller for the single-cycle RV32I core.
// It produces the per-cycle commit enable (cpu_en) and supports halt,
// single-step, free run, run-N with an instruction budget, and a PC
// breakpoint. It can also dump all 32 GPRs over a valid/ready stream by
// driving the core's debug register-select port.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   cmd_valid/ready/op/arg   command channel (op: 0 NOP 1 HALT 2 STEP 3 RUN 4 RUN_N 5 DUMP)
//   bp_en, bp_addr, pc_in    breakpoint control and current core PC
//   cpu_en                   core commits the current instruction this edge
//   reg_sel, reg_data        core debug register port
//   dump_valid/ready/data/idx  GPR dump stream
//   state                    0 HALT, 1 STEP, 2 RUN, 3 DUMP
//   bp_hit                   last run stopped on the breakpoint (sticky)
//   retired                  count of cycles with cpu_en=1 (wraps)
module cpu_run_ctrl #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          RESET_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc_in,
    output logic             cpu_en,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [31:0]      dump_data,
    output logic [4:0]       dump_idx,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DUMP = 2'd3;

    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_STEP  = 3'd2;
    localparam logic [2:0] OP_RUN   = 3'd3;
    localparam logic [2:0] OP_RUN_N = 3'd4;
    localparam logic [2:0] OP_DUMP  = 3'd5;

    localparam logic [4:0] LAST_REG = 5'd31;

    logic [1:0]       r_state;
    logic             r_first;
    logic [CNT_W-1:0] r_budget;   // 0 means unbudgeted run
    logic [4:0]       r_reg_sel;
    logic             r_bp_hit;
    logic [CNT_W-1:0] r_retired;

    logic [1:0]       w_state_nx;
    logic             w_first_nx;
    logic [CNT_W-1:0] w_budget_nx;
    logic [4:0]       w_reg_sel_nx;
    logic             w_bp_hit_nx;

    logic w_cmd_acc;
    logic w_cmd_real;
    logic w_stop_bp;
    logic w_stop_cmd;

    // Combinational handshake, stop conditions and commit enable
    assign cmd_ready  = (r_state == ST_HALT) || (r_state == ST_RUN);
    assign w_cmd_acc  = cmd_valid && cmd_ready;
    assign w_cmd_real = w_cmd_acc && (cmd_op >= OP_HALT) && (cmd_op <= OP_DUMP);
    assign w_stop_bp  = bp_en && (pc_in == bp_addr) && !r_first;
    assign w_stop_cmd = cmd_valid && (cmd_op == OP_HALT);
    assign cpu_en     = (r_state == ST_STEP) ||
                        ((r_state == ST_RUN) && !w_stop_bp && !w_stop_cmd);

    assign dump_valid = (r_state == ST_DUMP);
    assign dump_idx   = r_reg_sel;
    assign dump_data  = reg_data;
    assign reg_sel    = r_reg_sel;
    assign state      = r_state;
    assign bp_hit     = r_bp_hit;
    assign retired    = r_retired;

    // Next-state logic
    always_comb begin
        w_state_nx   = r_state;
        w_first_nx   = r_first;
        w_budget_nx  = r_budget;
        w_reg_sel_nx = r_reg_sel;
        w_bp_hit_nx  = r_bp_hit;

        // A new operation clears the sticky flag; a set below overrides it
        if (w_cmd_real) begin
            w_bp_hit_nx = 1'b0;
        end

        case (r_state)
            ST_HALT: begin
                if (w_cmd_acc) begin
                    case (cmd_op)
                        OP_STEP: w_state_nx = ST_STEP;
                        OP_RUN: begin
                            w_state_nx  = ST_RUN;
                            w_first_nx  = 1'b1;
                            w_budget_nx = CNT_W'(0);
                        end
                        OP_RUN_N: begin
                            if (cmd_arg != CNT_W'(0)) begin
                                w_state_nx  = ST_RUN;
                                w_first_nx  = 1'b1;
                                w_budget_nx = cmd_arg;
                            end
                        end
                        OP_DUMP: begin
                            w_state_nx   = ST_DUMP;
                            w_reg_sel_nx = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                w_state_nx = ST_HALT;
            end
            ST_RUN: begin
                w_first_nx = 1'b0;
                if (w_stop_cmd) begin
                    w_state_nx = ST_HALT;
                end else if (w_stop_bp) begin
                    w_state_nx  = ST_HALT;
                    w_bp_hit_nx = 1'b1;
                end else if (r_budget != CNT_W'(0)) begin
                    w_budget_nx = r_budget - CNT_W'(1);
                    if (r_budget == CNT_W'(1)) begin
                        w_state_nx = ST_HALT;
                    end
                end
            end
            ST_DUMP: begin
                if (dump_ready) begin
                    if (r_reg_sel == LAST_REG) begin
                        w_state_nx   = ST_HALT;
                        w_reg_sel_nx = 5'd0;
                    end else begin
                        w_reg_sel_nx = r_reg_sel + 5'd1;
                    end
                end
            end
            default: w_state_nx = ST_HALT;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RESET_RUN ? ST_RUN : ST_HALT;
            r_first   <= 1'b0;
            r_budget  <= CNT_W'(0);
            r_reg_sel <= 5'd0;
            r_bp_hit  <= 1'b0;
            r_retired <= CNT_W'(0);
        end else begin
            r_state   <= w_state_nx;
            r_first   <= w_first_nx;
            r_budget  <= w_budget_nx;
            r_reg_sel <= w_reg_sel_nx;
            r_bp_hit  <= w_bp_hit_nx;
            if (cpu_en) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: step, run-N, breakpoint, halt
// priority, GPR dump with back-pressure, and asynchronous reset mid-operation.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_in;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] retired;

    int n_cmp;
    int n_err;

    cpu_run_ctrl #(.CNT_W(32), .RESET_RUN(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_in      (pc_in),
        .cpu_en     (cpu_en),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .state      (state),
        .bp_hit     (bp_hit),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core register file model: GPR i reads as i*0x11111111
    always_comb reg_data = 32'(reg_sel) * 32'h11111111;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
        bp_en = 1'b0; bp_addr = 32'd0; pc_in = 32'd0; dump_ready = 1'b0;
        #3;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end
        n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d exp 0", retired); end
        n_cmp++; if (dump_valid !== 1'b0 || reg_sel !== 5'd0 || bp_hit !== 1'b0) begin
            n_err++; $display("FAIL reset_misc got dv=%b sel=%0d bp=%b exp 0/0/0", dump_valid, reg_sel, bp_hit); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_step();
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(i * 4);
            cmd_valid = 1'b1; cmd_op = 3'd2;
            #1;
            n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL step_pre_en[%0d] got %b exp 0", i, cpu_en); end
            tick();
            cmd_valid = 1'b0; cmd_op = 3'd0;
            #1;
            n_cmp++; if (state !== 2'd1 || cpu_en !== 1'b1 || cmd_ready !== 1'b0) begin
                n_err++; $display("FAIL step_active[%0d] got st=%0d en=%b rdy=%b exp 1/1/0", i, state, cpu_en, cmd_ready); end
            tick();
            n_cmp++; if (state !== 2'd0 || cpu_en !== 1'b0) begin
                n_err++; $display("FAIL step_done[%0d] got st=%0d en=%b exp 0/0", i, state, cpu_en); end
        end
        n_cmp++; if (retired !== 32'd3) begin n_err++; $display("FAIL step_retired got %0d exp 3", retired); end
    endtask

    task automatic test_run_n();
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_arg = 32'd5;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        for (int k = 0; k < 5; k++) begin
            pc_in = 32'h100 + 32'(k * 4);
            #1;
            n_cmp++; if (state !== 2'd2 || cpu_en !== 1'b1) begin
                n_err++; $display("FAIL runn_cycle[%0d] got st=%0d en=%b exp 2/1", k, state, cpu_en); end
            tick();
        end
        n_cmp++; if (state !== 2'd0 || cpu_en !== 1'b0 || bp_hit !== 1'b0) begin
            n_err++; $display("FAIL runn_end got st=%0d en=%b bp=%b exp 0/0/0", state, cpu_en, bp_hit); end
        n_cmp++; if (retired !== 32'd8) begin n_err++; $display("FAIL runn_retired got %0d exp 8", retired); end
        // Zero budget: stays halted, nothing retires
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_arg = 32'd0;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        #1;
        n_cmp++; if (state !== 2'd0 || cpu_en !== 1'b0) begin
            n_err++; $display("FAIL runn0_state got st=%0d en=%b exp 0/0", state, cpu_en); end
        tick();
        n_cmp++; if (retired !== 32'd8) begin n_err++; $display("FAIL runn0_retired got %0d exp 8", retired); end
    endtask

    task automatic test_breakpoint();
        bp_en = 1'b1; bp_addr = 32'h10; pc_in = 32'h0;
        cmd_valid = 1'b1; cmd_op = 3'd3;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        for (int k = 0; k < 4; k++) begin
            pc_in = 32'(k * 4);
            #1;
            n_cmp++; if (cpu_en !== 1'b1 || state !== 2'd2) begin
                n_err++; $display("FAIL bp_run[%0d] got en=%b st=%0d exp 1/2", k, cpu_en, state); end
            tick();
        end
        pc_in = 32'h10;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL bp_stop_en got %b exp 0", cpu_en); end
        tick();
        n_cmp++; if (state !== 2'd0 || bp_hit !== 1'b1 || retired !== 32'd12) begin
            n_err++; $display("FAIL bp_stopped got st=%0d bp=%b ret=%0d exp 0/1/12", state, bp_hit, retired); end
        // Relaunch from the breakpoint PC: first instruction commits, flag clears
        cmd_valid = 1'b1; cmd_op = 3'd3;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        #1;
        n_cmp++; if (cpu_en !== 1'b1 || state !== 2'd2 || bp_hit !== 1'b0) begin
            n_err++; $display("FAIL bp_relaunch got en=%b st=%0d bp=%b exp 1/2/0", cpu_en, state, bp_hit); end
        tick();
        pc_in = 32'h14;
        #1;
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL bp_past got en=%b exp 1", cpu_en); end
        tick();
    endtask

    task automatic test_halt_priority();
        // Still running from test_breakpoint with first cleared
        pc_in = 32'h10;
        cmd_valid = 1'b1; cmd_op = 3'd1;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL halt_pri_en got %b exp 0", cpu_en); end
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        n_cmp++; if (state !== 2'd0 || bp_hit !== 1'b0 || retired !== 32'd14) begin
            n_err++; $display("FAIL halt_pri got st=%0d bp=%b ret=%0d exp 0/0/14", state, bp_hit, retired); end
        bp_en = 1'b0;
    endtask

    task automatic test_dump();
        logic [31:0] exp_d;
        logic [31:0] held;
        cmd_valid = 1'b1; cmd_op = 3'd5;
        tick();
        cmd_op = 3'd3;  // keep offering a command; it must not be accepted
        for (int i = 0; i < 32; i++) begin
            exp_d = 32'(i) * 32'h11111111;
            if (i > 0) begin
                dump_ready = 1'b0;
                #1;
                held = dump_data;
                tick();
                n_cmp++; if (dump_idx !== 5'(i) || dump_data !== held || dump_valid !== 1'b1) begin
                    n_err++; $display("FAIL dump_stall[%0d] got idx=%0d d=%h v=%b exp %0d/%h/1", i, dump_idx, dump_data, dump_valid, i, held); end
            end
            dump_ready = 1'b1;
            #1;
            n_cmp++; if (dump_valid !== 1'b1 || dump_idx !== 5'(i) || dump_data !== exp_d || cmd_ready !== 1'b0 || cpu_en !== 1'b0) begin
                n_err++; $display("FAIL dump_beat[%0d] got v=%b idx=%0d d=%h rdy=%b en=%b exp 1/%0d/%h/0/0",
                                  i, dump_valid, dump_idx, dump_data, cmd_ready, cpu_en, i, exp_d); end
            tick();
        end
        cmd_valid = 1'b0; cmd_op = 3'd0; dump_ready = 1'b0;
        n_cmp++; if (state !== 2'd0 || dump_valid !== 1'b0 || reg_sel !== 5'd0 || retired !== 32'd14) begin
            n_err++; $display("FAIL dump_end got st=%0d v=%b sel=%0d ret=%0d exp 0/0/0/14", state, dump_valid, reg_sel, retired); end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_op = 3'd5;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0; dump_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        dump_ready = 1'b0;
        n_cmp++; if (dump_idx !== 5'd7 || state !== 2'd3) begin
            n_err++; $display("FAIL mid_dump_idx got idx=%0d st=%0d exp 7/3", dump_idx, state); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (state !== 2'd0 || dump_valid !== 1'b0 || reg_sel !== 5'd0 || retired !== 32'd0 || cpu_en !== 1'b0) begin
            n_err++; $display("FAIL rst_in_dump got st=%0d v=%b sel=%0d ret=%0d en=%b exp 0/0/0/0/0",
                              state, dump_valid, reg_sel, retired, cpu_en); end
        reset = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_op = 3'd3;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        tick();
        n_cmp++; if (state !== 2'd2 || cpu_en !== 1'b1 || retired !== 32'd1) begin
            n_err++; $display("FAIL mid_run got st=%0d en=%b ret=%0d exp 2/1/1", state, cpu_en, retired); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (state !== 2'd0 || cpu_en !== 1'b0 || retired !== 32'd0 || reg_sel !== 5'd0) begin
            n_err++; $display("FAIL rst_in_run got st=%0d en=%b ret=%0d sel=%0d exp 0/0/0/0", state, cpu_en, retired, reg_sel); end
        reset = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0 || retired !== 32'd0) begin
            n_err++; $display("FAIL post_rst got st=%0d ret=%0d exp 0/0", state, retired); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_step();
        test_run_n();
        test_breakpoint();
        test_halt_priority();
        test_dump();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
